// File: rtl/rst_pkg.sv
// Shared types for the reset sequencer: cause codes, FSM states, and counter sizing.
package rst_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    POR  = 2'b01,
    BTN  = 2'b10
  } rst_cause_e;

  typedef enum logic [1:0] {
    ASSERT  = 2'b00,
    HOLD    = 2'b01,
    RELEASE = 2'b10,
    RUN     = 2'b11
  } seq_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton path: 2-flop synchronizer followed by a consecutive-sample debouncer.
module btn_debounce
  import rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic pressed
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST =
    (DEBOUNCE_CYCLES == 0) ? '0 : CW'(DEBOUNCE_CYCLES - 1);

  logic sync1_q, sync2_q;
  logic lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt tracks consecutive samples that disagree with the accepted level
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q >= LAST) lvl_d = sync2_q;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = ~lvl_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release after POR or a debounced button press.
// Button path compiled in only when RST_SEQ_BTN_EN is defined.
module reset_sequencer
  import rst_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned MIN_HOLD        = 16,
  parameter int unsigned STAGE_GAP       = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  btn_n,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  ready,
  output logic [1:0]            rst_cause
);

  localparam int unsigned HW = cnt_w(MIN_HOLD);
  localparam int unsigned GW = cnt_w(STAGE_GAP);
  localparam int unsigned IW = cnt_w(NUM_STAGES);

  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
  localparam logic [GW-1:0] GAP_LAST =
    (STAGE_GAP == 0) ? '0 : GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

  seq_state_e state_q, state_d;
  rst_cause_e cause_q, cause_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic ready_q, ready_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] idx_q, idx_d;
  logic btn_press;

`ifdef RST_SEQ_BTN_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_n  (btn_n),
    .pressed(btn_press)
  );
`else
  logic unused_btn;
  assign unused_btn = btn_n & (DEBOUNCE_CYCLES != 0);
  assign btn_press  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    stage_d = stage_q;
    ready_d = ready_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    if (btn_press) begin
      state_d = ASSERT;
      cause_d = BTN;
      stage_d = '0;
      ready_d = 1'b0;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ASSERT: begin
          state_d = HOLD;
          hold_d  = '0;
        end
        HOLD: begin
          if (hold_q >= HOLD_MAX) begin
            stage_d[0] = 1'b1;
            gap_d      = '0;
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
              idx_d   = IW'(1);
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        RELEASE: begin
          if (gap_q >= GAP_LAST) begin
            for (int i = 0; i < int'(NUM_STAGES); i++)
              if (idx_q == IW'(i)) stage_d[i] = 1'b1;
            gap_d = '0;
            // ready rises together with the final stage
            if (idx_q >= IDX_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        RUN: ;
        default: state_d = ASSERT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ASSERT;
      cause_q <= POR;
      stage_q <= '0;
      ready_q <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
    end
  end

  assign stage_rst_n = stage_q;
  assign ready       = ready_q;
  assign rst_cause   = cause_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of sequenced reset outputs (1..8).
REQ-002 SHALL have parameter MIN_HOLD, default 16, cycles all stages stay asserted after a reset cause clears.
REQ-003 SHALL have parameter STAGE_GAP, default 1000, cycles between consecutive stage releases.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable samples needed to accept a button level.
REQ-005 SHALL have port clk  input  1  system clock; the only clock.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous to clk and active-low, driven by the power-on reset generator.
REQ-007 SHALL have port btn_n  input  1  user reset pushbutton, active-low, asynchronous to clk.
REQ-008 SHALL have port stage_rst_n  output  NUM_STAGES  per-domain active-low resets, released in index order.
REQ-009 SHALL have port ready  output  1  high when all stages are released.
REQ-010 SHALL have port rst_cause  output  2  cause of the last sequence: 00 none, 01 POR, 10 button.

Function
REQ-011 SHALL implement states ASSERT, HOLD, RELEASE and RUN.
REQ-012 In ASSERT, all stage_rst_n bits SHALL be 0 and ready SHALL be 0.
REQ-013 ASSERT SHALL move to HOLD on the first edge with reset_n=1 and the debounced button released, with hold counter = 0.
REQ-014 HOLD SHALL count MIN_HOLD cycles, then set stage_rst_n[0]=1 and enter RELEASE with stage index 1 and gap counter = 0.
REQ-015 Result of REQ-013/014: stage_rst_n[0] rises exactly MIN_HOLD+1 edges after the first edge at which reset_n is sampled 1.
REQ-016 RELEASE SHALL set stage_rst_n[k]=1 exactly STAGE_GAP cycles after stage_rst_n[k-1]; after the last stage, it SHALL enter RUN.
REQ-017 ready SHALL rise on the same edge as stage_rst_n[NUM_STAGES-1]; with NUM_STAGES=1, HOLD goes directly to RUN.
REQ-018 A released stage SHALL remain 1 until the FSM re-enters ASSERT; outputs never glitch mid-sequence.
REQ-019 btn_n SHALL pass a 2-flop synchronizer, then a debouncer that changes its output only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-020 A debounced press, in any non-reset state including mid-HOLD or mid-RELEASE, SHALL force ASSERT on the next edge and set rst_cause=10.
REQ-021 While the debounced button remains pressed, the FSM SHALL stay in ASSERT; the sequence restarts from HOLD after the debounced release.
REQ-022 Counters SHALL saturate, not wrap; widths SHALL be $clog2(param+1).
REQ-023 If reset_n falls on the same edge as a debounced press, reset_n SHALL win and rst_cause SHALL be 01.

Reset
REQ-024 With reset_n=0 at an edge: state=ASSERT, stage_rst_n=0, ready=0, rst_cause=01, counters=0, and debouncer output = released.
REQ-025 Synchronizer flops SHALL reset to 1 (released); reset_n SHALL NOT drive any flop asynchronously.

Configuration
REQ-026 Macro RST_SEQ_BTN_EN defined: button path per REQ-019..021 is compiled in.
REQ-027 Macro RST_SEQ_BTN_EN undefined: btn_n is ignored, no debouncer is instantiated, rst_cause is only 00/01, and only reset_n starts a sequence.

Structure
REQ-028 Shared package rst_pkg SHALL hold the rst_cause_e enum (NONE, POR, BTN) and the FSM state enum.
REQ-029 The synchronizer and debouncer SHALL be sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, reset_n, btn_n, pressed).

Verification
Bench params for all scenarios: NUM_STAGES=4, MIN_HOLD=4, STAGE_GAP=8, DEBOUNCE_CYCLES=5.
REQ-030 POR: reset_n low 10 cycles then high -> stage_rst_n[0] high at edge 5 after release, [1] at 13, [2] at 21, [3] at 29 with ready=1, rst_cause=01.
REQ-031 Button press: btn_n low 20 cycles in RUN -> all stages 0 about 7 cycles after press (2 sync + 5 debounce), rst_cause=10, sequence restarts after debounced release.
REQ-032 Bounce: btn_n toggled every 3 cycles for 30 cycles -> no change on stage_rst_n or ready.
REQ-033 Mid-sequence press: debounced press right after stage_rst_n[1] rises -> all stages 0 next edge, then a full sequence from HOLD.
REQ-034 Simultaneous event: reset_n low on the same edge as debounced press -> ASSERT with rst_cause=01.
REQ-035 RST_SEQ_BTN_EN undefined: btn_n held low 100 cycles in RUN -> outputs unchanged and ready=1.
